muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width; legal values are even and at least 8.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port gr1  input  WIDTH  rs operand; multiplicand or dividend.
REQ-007 SHALL have port gr2  input  WIDTH  rt operand; multiplier or divisor.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse; hi and lo are valid from this cycle.
REQ-010 SHALL have port hi  output  WIDTH  product upper half, or remainder.
REQ-011 SHALL have port lo  output  WIDTH  product lower half, or quotient.
REQ-012 SHALL have port dz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-014 SHALL, in IDLE with start=1, latch op, gr1 and gr2, load the iteration counter with WIDTH and enter CALC; start is ignored in every other state.
REQ-015 SHALL, in CALC, perform exactly one iteration per cycle on operand magnitudes: a shift-add step for multiply, a restoring shift-subtract step for divide.
REQ-016 SHALL decrement the counter once per CALC cycle and move to FIX on the cycle its last iteration completes (WIDTH CALC cycles).
REQ-017 SHALL, in FIX, apply sign correction and write hi and lo: signed product negated when the operand signs differ; quotient negated when the operand signs differ; remainder takes the dividend's sign.
REQ-018 SHALL assert done for exactly the one DONE cycle, WIDTH+2 cycles after the start-sampling edge, then return to IDLE.
REQ-019 SHALL leave unsigned ops (MULTU, DIVU) uncorrected; MULT and DIV treat gr1 and gr2 as two's complement.
REQ-020 SHALL, for DIV of the most-negative value by -1, produce lo = most-negative value and hi = 0 with no flag.
REQ-021 SHALL hold hi and lo stable between completions; a new start does not alter them before its own FIX cycle.
REQ-022 SHALL allow start in the cycle after done (back-to-back ops) with no bubble beyond the IDLE cycle.

Reset
REQ-023 SHALL, on rst=1 in any state including mid-CALC, enter IDLE and clear hi, lo, busy, done, dz and the counter to 0; the in-flight operation is discarded.
REQ-024 SHALL give rst priority over start in the same cycle.

Configuration
REQ-025 SHALL, with MULDIV_DIVZERO_CHECK_EN defined, detect gr2 = 0 on a DIV or DIVU start, skip CALC and FIX, and enter DONE on the next edge (done 1 cycle after start) with lo = all ones, hi = gr1 and dz = 1; any other completion clears dz.
REQ-026 SHALL, without MULDIV_DIVZERO_CHECK_EN, run division by zero through the normal WIDTH+2 latency with the natural restoring result (DIVU: lo = all ones, hi = gr1) and tie dz to 0.

Structure
REQ-027 SHALL place the op encoding enum, the FSM state enum and the op-decode helper constants in shared package muldiv_pkg.
REQ-028 SHALL use one sub-module, muldiv_abs: combinational two's-complement magnitude and conditional negate, instanced for operand absolute values and FIX correction.

Verification (WIDTH=32)
REQ-029 SHALL cover MULT with gr1 = FFFFFFFF, gr2 = 00000001 -> hi = FFFFFFFF, lo = FFFFFFFF, done 34 cycles after start; the same inputs with MULTU -> hi = 00000000, lo = FFFFFFFF.
REQ-030 SHALL cover DIV with gr1 = FFFFFFE1, gr2 = 00000011 -> lo = FFFFFFFF, hi = FFFFFFF2; DIVU with gr1 = 0000000D, gr2 = 00000001 -> lo = 0000000D, hi = 00000000.
REQ-031 SHALL cover DIV with gr1 = 80000000, gr2 = FFFFFFFF -> lo = 80000000, hi = 00000000, dz = 0.
REQ-032 SHALL cover a second start pulse during CALC and changes to gr1/gr2 during CALC -> both ignored, result from the latched operands, single done pulse.
REQ-033 SHALL cover rst asserted at CALC cycle 10 -> IDLE next edge, all outputs 0, no done; a following MULTU of 3 x 5 -> lo = 0000000F.
REQ-034 SHALL cover DIVU with gr1 = 00000007, gr2 = 0 in both macro builds -> with the macro: done after 1 cycle, dz = 1, lo = FFFFFFFF, hi = 00000007; without the macro: done after 34 cycles, same hi/lo, dz = 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and op-decode constants for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  // op[OP_DIV_BIT] selects divide, op[OP_UNS_BIT] selects unsigned
  localparam int OP_DIV_BIT = 1;
  localparam int OP_UNS_BIT = 0;

endpackage

// File: rtl/muldiv_abs.sv
// Combinational two's-complement conditional negate; with neg = sign bit it yields the magnitude.
module muldiv_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? -a : a;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide: one shift-add or restoring shift-subtract step per cycle.
// Optional fast divide-by-zero completion when MULDIV_DIVZERO_CHECK_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] gr1,
  input  logic [WIDTH-1:0] gr2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               is_div_r, neg_q, neg_r;
  logic [WIDTH-1:0]   acc_hi, acc_lo, mag_b;
  logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic               op_signed, q_bit, divz;

  assign op_signed = ~op[OP_UNS_BIT];

  muldiv_abs #(.W(WIDTH))   u_abs_a (.a(gr1), .neg(op_signed & gr1[WIDTH-1]), .y(a_mag));
  muldiv_abs #(.W(WIDTH))   u_abs_b (.a(gr2), .neg(op_signed & gr2[WIDTH-1]), .y(b_mag));
  muldiv_abs #(.W(2*WIDTH)) u_fix_p (.a({acc_hi, acc_lo}), .neg(neg_q), .y(prod_fix));
  muldiv_abs #(.W(WIDTH))   u_fix_q (.a(acc_lo), .neg(neg_q), .y(quo_fix));
  muldiv_abs #(.W(WIDTH))   u_fix_r (.a(acc_hi), .neg(neg_r), .y(rem_fix));

`ifdef MULDIV_DIVZERO_CHECK_EN
  logic dz_q;
  assign divz = op[OP_DIV_BIT] && (gr2 == '0);
  assign dz   = dz_q;

  always_ff @(posedge clk) begin
    if (rst)                                 dz_q <= 1'b0;
    else if (state == S_IDLE && start && divz) dz_q <= 1'b1;
    else if (state == S_FIX)                 dz_q <= 1'b0;
  end
`else
  assign divz = 1'b0;
  assign dz   = 1'b0;
`endif

  // Multiply: acc_lo holds the multiplier and shifts product bits in from the top.
  // Divide: acc_lo holds the dividend and shifts quotient bits in from the bottom.
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, mag_b};
  assign q_bit    = ~div_diff[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = divz ? S_DONE : S_CALC;
      S_CALC:  if (cnt == CW'(1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      is_div_r <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mag_b    <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cnt      <= CW'(WIDTH);
          is_div_r <= op[OP_DIV_BIT];
          neg_q    <= op_signed & (gr1[WIDTH-1] ^ gr2[WIDTH-1]);
          neg_r    <= op_signed & gr1[WIDTH-1];
          acc_hi   <= '0;
          acc_lo   <= op[OP_DIV_BIT] ? a_mag : b_mag;
          mag_b    <= op[OP_DIV_BIT] ? b_mag : a_mag;
          if (divz) begin
            hi <= gr1;
            lo <= '1;
          end
        end
        S_CALC: begin
          cnt <= cnt - CW'(1);
          if (is_div_r) begin
            acc_hi <= q_bit ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], q_bit};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (is_div_r) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
